// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command path.
// No logic; widths and field positions for the 32-bit command word.
// Opcode/address/data slice points are derived from the field widths.
package spi_ctrl_pkg;

    localparam int WORD_W   = 32;
    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = WORD_W - OPCODE_W - ADDR_W;
    localparam int CNT_W    = 8;

    // Field slice points inside a command word (MSB positions)
    localparam int OPC_MSB  = WORD_W - 1;
    localparam int ADDR_MSB = WORD_W - OPCODE_W - 1;
    localparam int DATA_MSB = DATA_W - 1;

    localparam logic [OPCODE_W-1:0] OPC_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] OPC_WRITE = 4'h1;
    localparam logic [OPCODE_W-1:0] OPC_READ  = 4'h2;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/spi_word_assembler.sv
// Shifts synchronized MOSI bits MSB-first into words and flags incomplete frames.
// Latency: word_done/word are combinational on the final strobe; frame_err is registered (1 cycle).
// No backpressure: bits are always accepted while the frame is active.
module spi_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_active,
    input  logic              bit_strobe,
    input  logic              bit_value,
    input  logic              in_recv,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic              frame_err
);

    localparam int BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic              take_bit;

    // A strobe only counts while chip select is active, even in the same cycle it drops
    assign take_bit  = frame_active & bit_strobe;
    assign word      = {shift_reg[WORD_W-2:0], bit_value};
    assign word_done = take_bit && (bit_cnt == LAST_BIT);

    // Shift register, bit counter and the short-frame pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= in_recv && !frame_active && (bit_cnt != '0);
            if (!frame_active) begin
                // Partial word is abandoned; the next frame starts at bit 0
                bit_cnt <= '0;
            end else if (take_bit) begin
                shift_reg <= word;
                bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Frames SPI slave bits into command words and presents them on a valid/ready port.
// Latency: cmd_valid rises 1 clock after the final bit strobe of a word.
// Backpressure: one-entry hold; a word completing while held and not accepted is dropped and flagged.
module spi_frame_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int WORD_W   = spi_ctrl_pkg::WORD_W,
    parameter int OPCODE_W = spi_ctrl_pkg::OPCODE_W,
    parameter int ADDR_W   = spi_ctrl_pkg::ADDR_W,
    parameter int CNT_W    = spi_ctrl_pkg::CNT_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             frame_active,
    input  logic                             bit_strobe,
    input  logic                             bit_value,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [OPCODE_W-1:0]              cmd_opcode,
    output logic [ADDR_W-1:0]                cmd_addr,
    output logic [WORD_W-OPCODE_W-ADDR_W-1:0] cmd_data,
    output logic                             frame_err,
    output logic                             overrun,
    input  logic                             overrun_clr,
    output logic [CNT_W-1:0]                 cmd_count
);

    localparam int D_W = WORD_W - OPCODE_W - ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic              in_recv;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              word_live;
    logic              accept;
    logic              load;
    logic              drop;

    spi_word_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clock        (clock),
        .reset        (reset),
        .frame_active (frame_active),
        .bit_strobe   (bit_strobe),
        .bit_value    (bit_value),
        .in_recv      (in_recv),
        .word         (word),
        .word_done    (word_done),
        .frame_err    (frame_err)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a frame is entered on chip select and left when it drops
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_active)  state_nxt = RECV;
            RECV:    if (!frame_active) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_recv = (state == RECV);
    end

    // NOP words vanish here; everything else either loads the hold register or is dropped
    assign word_live = word_done && (word[WORD_W-1 -: OPCODE_W] != OPCODE_W'(OPC_NOP));
    assign accept    = cmd_valid && cmd_ready;
    assign load      = word_live && (!cmd_valid || cmd_ready);
    assign drop      = word_live && cmd_valid && !cmd_ready;

    // Command hold register: payload only changes when empty or being consumed this cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_opcode <= '0;
            cmd_addr   <= '0;
            cmd_data   <= '0;
        end else begin
            if (load) begin
                cmd_valid  <= 1'b1;
                cmd_opcode <= word[WORD_W-1 -: OPCODE_W];
                cmd_addr   <= word[WORD_W-OPCODE_W-1 -: ADDR_W];
                cmd_data   <= word[D_W-1:0];
            end else if (accept) begin
                cmd_valid  <= 1'b0;
            end
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Saturating count of consumed commands
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_count <= '0;
        end else if (accept && (cmd_count != '1)) begin
            cmd_count <= cmd_count + 1'b1;
        end
    end

endmodule
